// File: rtl/apuf_multi_eval.sv
// apuf_multi_eval: multi-chain arbiter-PUF evaluation engine.
// Latches a challenge, fires the launch trigger nRep times with SETTLE-cycle
// relax/fire windows, counts arbiter ones per chain and majority-votes them.
// Optional build macro APUF_XOR_EN: when defined, resp_xor is the registered
// XOR of all voted responses; when undefined, resp_xor is tied low.
module apuf_multi_eval #(
  parameter int nStage = 64,
  parameter int nChain = 4,
  parameter int nRep   = 5,
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [nStage-1:0] chal,
  output logic [nStage-1:0] chal_o,
  output logic              trig_o,
  input  logic [nChain-1:0] arb_i,
  output logic              busy,
  output logic              done,
  output logic [nChain-1:0] resp,
  output logic [nChain-1:0] unstable,
  output logic              resp_xor
);

  localparam int CW = $clog2(nRep + 1);
  localparam int SW = $clog2(SETTLE + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RELAX  = 3'd1;
  localparam logic [2:0] S_FIRE   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_VOTE   = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [SW-1:0]     settle_cnt;
  logic [CW-1:0]     rep_cnt;
  logic [CW-1:0]     ones     [nChain];
  logic [CW-1:0]     ones_sum [nChain];
  logic [nChain-1:0] sync1;
  logic [nChain-1:0] sync2;
  logic [nChain-1:0] vote_resp;
  logic [nChain-1:0] vote_unst;
  logic              settle_done;
  logic              last_rep;

  assign settle_done = (settle_cnt == SW'(SETTLE - 1));
  assign last_rep    = (rep_cnt == CW'(nRep - 1));

  // Next-state logic: relax and fire windows each last SETTLE cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_RELAX;
      S_RELAX:  if (settle_done) state_nxt = S_FIRE;
      S_FIRE:   if (settle_done) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = last_rep ? S_VOTE : S_RELAX;
      S_VOTE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Per-chain tally including the current sample, and the vote derived from it.
  always_comb begin
    vote_resp = '0;
    vote_unst = '0;
    for (int k = 0; k < nChain; k++) begin
      ones_sum[k]  = ones[k] + CW'(sync2[k]);
      vote_resp[k] = (ones_sum[k] > CW'(nRep / 2));
      vote_unst[k] = (ones_sum[k] != '0) && (ones_sum[k] != CW'(nRep));
    end
  end

  // Settle counter restarts at every window boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if ((state == S_RELAX || state == S_FIRE) && !settle_done) begin
      settle_cnt <= settle_cnt + 1'b1;
    end else begin
      settle_cnt <= '0;
    end
  end

  // Two-flop synchroniser for the asynchronous arbiter outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= arb_i;
      sync2 <= sync1;
    end
  end

  // FSM state and registered control outputs, decoded from the next state so
  // trig_o, busy and done come straight off flops and never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      trig_o <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      trig_o <= (state_nxt == S_FIRE) || (state_nxt == S_SAMPLE);
      busy   <= (state_nxt != S_IDLE);
      done   <= (state_nxt == S_VOTE);
    end
  end

  // Challenge latch, rep/ones counters and vote results; the vote is captured
  // on the final sample edge so resp/unstable are valid in the same cycle as done.
  always_ff @(posedge clk) begin
    if (rst) begin
      chal_o   <= '0;
      rep_cnt  <= '0;
      resp     <= '0;
      unstable <= '0;
      for (int k = 0; k < nChain; k++) ones[k] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            chal_o  <= chal;
            rep_cnt <= '0;
            for (int k = 0; k < nChain; k++) ones[k] <= '0;
          end
        end
        S_SAMPLE: begin
          rep_cnt <= rep_cnt + 1'b1;
          for (int k = 0; k < nChain; k++) ones[k] <= ones_sum[k];
          if (last_rep) begin
            resp     <= vote_resp;
            unstable <= vote_unst;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef APUF_XOR_EN
  // XOR-APUF response, captured together with the voted responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_xor <= 1'b0;
    end else if (state == S_SAMPLE && last_rep) begin
      resp_xor <= ^vote_resp;
    end
  end
`else
  assign resp_xor = 1'b0;
`endif

endmodule
